// File: rtl/memfifo_pckt_reader.sv
// Drains PCKTS*WORDS_PER_PCKT 64-bit words from the memory FIFO and slices each into four 16-bit beats, LSB first.
// Latency RE->first beat is RD_LATENCY+1 clocks; a stalled beat (VALID & !READY) holds DOUT/SOP/EOP stable.
module memfifo_pckt_reader #(
  parameter int WORDS_PER_PCKT = 2,
  parameter int RD_LATENCY     = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MEMFIFO_DATA_READY,
  input  logic [15:0] MEMFIFO_DATA_PCKTS,
  input  logic [63:0] MEMFIFO_DATA,
  output logic        MEMFIFO_RE,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        DOUT_SOP,
  output logic        DOUT_EOP,
  output logic        BUSY,
  output logic        XFER_DONE
);

  localparam int WL_W  = 16 + $clog2(WORDS_PER_PCKT) + 1;
  localparam int WIP_W = (WORDS_PER_PCKT > 1) ? $clog2(WORDS_PER_PCKT) : 1;
  localparam logic [1:0]       LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [WIP_W-1:0] WIP_LAST = WIP_W'(WORDS_PER_PCKT - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic              armed, armed_nxt;
  logic [WL_W-1:0]   words_left, words_left_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic [1:0]        beat, beat_nxt;
  logic [WIP_W-1:0]  word_in_pckt, word_in_pckt_nxt;
  logic [63:0]       hold, hold_nxt;

  logic              re_nxt, valid_nxt, sop_nxt, eop_nxt, busy_nxt, done_nxt;
  logic [15:0]       dout_nxt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      armed        <= 1'b1;
      words_left   <= '0;
      lat_cnt      <= '0;
      beat         <= '0;
      word_in_pckt <= '0;
      hold         <= '0;
      MEMFIFO_RE   <= 1'b0;
      DOUT         <= '0;
      DOUT_VALID   <= 1'b0;
      DOUT_SOP     <= 1'b0;
      DOUT_EOP     <= 1'b0;
      BUSY         <= 1'b0;
      XFER_DONE    <= 1'b0;
    end else begin
      state        <= state_nxt;
      armed        <= armed_nxt;
      words_left   <= words_left_nxt;
      lat_cnt      <= lat_cnt_nxt;
      beat         <= beat_nxt;
      word_in_pckt <= word_in_pckt_nxt;
      hold         <= hold_nxt;
      MEMFIFO_RE   <= re_nxt;
      DOUT         <= dout_nxt;
      DOUT_VALID   <= valid_nxt;
      DOUT_SOP     <= sop_nxt;
      DOUT_EOP     <= eop_nxt;
      BUSY         <= busy_nxt;
      XFER_DONE    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    armed_nxt        = armed;
    words_left_nxt   = words_left;
    lat_cnt_nxt      = lat_cnt;
    beat_nxt         = beat;
    word_in_pckt_nxt = word_in_pckt;
    hold_nxt         = hold;
    case (state)
      IDLE: begin
        if (MEMFIFO_DATA_READY && armed && (MEMFIFO_DATA_PCKTS != 16'd0)) begin
          words_left_nxt   = WL_W'(MEMFIFO_DATA_PCKTS) * WL_W'(WORDS_PER_PCKT);
          word_in_pckt_nxt = '0;
          armed_nxt        = 1'b0;
          state_nxt        = READ;
        end
      end
      READ: begin
        words_left_nxt = words_left - WL_W'(1);
        lat_cnt_nxt    = '0;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          hold_nxt  = MEMFIFO_DATA;
          beat_nxt  = '0;
          state_nxt = SHIFT;
        end else begin
          lat_cnt_nxt = lat_cnt + 2'd1;
        end
      end
      SHIFT: begin
        // VALID is always high in SHIFT, so READY alone marks acceptance.
        if (DOUT_READY) begin
          beat_nxt = beat + 2'd1;
          if (beat == 2'd3) begin
            word_in_pckt_nxt = (word_in_pckt == WIP_LAST) ? '0 : word_in_pckt + WIP_W'(1);
            state_nxt        = (words_left != '0) ? READ : DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!MEMFIFO_DATA_READY) armed_nxt = 1'b1;
  end

  // Outputs are computed from next-state values so every output comes straight from a flop.
  always_comb begin
    re_nxt    = (state_nxt == READ);
    valid_nxt = (state_nxt == SHIFT);
    done_nxt  = (state_nxt == DONE);
    busy_nxt  = (state_nxt != IDLE);
    dout_nxt  = valid_nxt ? hold_nxt[{beat_nxt, 4'b0000} +: 16] : 16'd0;
    sop_nxt   = valid_nxt && (beat_nxt == 2'd0) && (word_in_pckt_nxt == '0);
    eop_nxt   = valid_nxt && (beat_nxt == 2'd3) && (word_in_pckt_nxt == WIP_LAST);
  end

endmodule

// File: tb/tb_memfifo_pckt_reader.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops and compares accepted beats.
// Instance 0 uses defaults; instance 1 uses RD_LATENCY=3, WORDS_PER_PCKT=1.
module tb_memfifo_pckt_reader;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] W0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W1 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W2 = 64'h000C_000B_000A_0009;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_ready [2];
  logic [15:0] pckts [2];
  logic [63:0] mdata [2];
  logic        re [2];
  logic [15:0] dout [2];
  logic        dvalid [2];
  logic        drdy [2];
  logic        sop [2];
  logic        eop [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  memfifo_pckt_reader u0 (
    .CLK(clk), .RESET_N(rst_n), .MEMFIFO_DATA_READY(data_ready[0]), .MEMFIFO_DATA_PCKTS(pckts[0]),
    .MEMFIFO_DATA(mdata[0]), .MEMFIFO_RE(re[0]), .DOUT(dout[0]), .DOUT_VALID(dvalid[0]),
    .DOUT_READY(drdy[0]), .DOUT_SOP(sop[0]), .DOUT_EOP(eop[0]), .BUSY(busy[0]), .XFER_DONE(done[0])
  );

  memfifo_pckt_reader #(.WORDS_PER_PCKT(1), .RD_LATENCY(3)) u1 (
    .CLK(clk), .RESET_N(rst_n), .MEMFIFO_DATA_READY(data_ready[1]), .MEMFIFO_DATA_PCKTS(pckts[1]),
    .MEMFIFO_DATA(mdata[1]), .MEMFIFO_RE(re[1]), .DOUT(dout[1]), .DOUT_VALID(dvalid[1]),
    .DOUT_READY(drdy[1]), .DOUT_SOP(sop[1]), .DOUT_EOP(eop[1]), .BUSY(busy[1]), .XFER_DONE(done[1])
  );

  typedef struct packed {
    logic        inst;
    logic        sop;
    logic        eop;
    logic [15:0] d;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] fq0[$];
  logic [63:0] fq1[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // FIFO model: data appears RD_LATENCY clocks after RE is sampled, junk otherwise.
  logic [2:0] sr [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr[0] <= '0; sr[1] <= '0;
      mdata[0] <= '0; mdata[1] <= '0;
    end else begin
      sr[0] <= {sr[0][1:0], re[0]};
      sr[1] <= {sr[1][1:0], re[1]};
      if (re[0] && fq0.size() > 0) mdata[0] <= fq0.pop_front();
      else                         mdata[0] <= JUNK;
      if (sr[1][1] && fq1.size() > 0) mdata[1] <= fq1.pop_front();
      else                            mdata[1] <= JUNK;
    end
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   re_cnt [2]    = '{0, 0};
  int   done_cnt [2]  = '{0, 0};
  int   busy_cyc [2]  = '{0, 0};
  int   valid_cyc [2] = '{0, 0};
  int   sop_cnt [2]   = '{0, 0};
  int   eop_cnt [2]   = '{0, 0};
  int   first_re1  = -1;
  int   first_val1 = -1;
  logic stall_prev [2] = '{1'b0, 1'b0};
  logic [17:0] prev [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [18:0] obs;
      beat_t e;
      if (re[i])     re_cnt[i]++;
      if (done[i])   done_cnt[i]++;
      if (busy[i])   busy_cyc[i]++;
      if (dvalid[i]) valid_cyc[i]++;
      if (dvalid[i] && stall_prev[i]) chk("stall_hold", {46'd0, sop[i], eop[i], dout[i]}, {46'd0, prev[i]});
      stall_prev[i] = dvalid[i] && !drdy[i];
      prev[i] = {sop[i], eop[i], dout[i]};
      if (dvalid[i] && drdy[i]) begin
        if (sop[i]) sop_cnt[i]++;
        if (eop[i]) eop_cnt[i]++;
        obs = {i[0], sop[i], eop[i], dout[i]};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {45'd0, obs}, {45'd0, e});
        end
      end
    end
    if (re[1] && first_re1 < 0) first_re1 = cyc;
    if (dvalid[1] && first_val1 < 0) first_val1 = cyc;
  end

  task automatic push_word(input int i, input logic [63:0] w, input bit first, input bit last);
    beat_t e;
    if (i == 0) fq0.push_back(w);
    else        fq1.push_back(w);
    for (int b = 0; b < 4; b++) begin
      e.inst = i[0];
      e.sop  = first && (b == 0);
      e.eop  = last && (b == 3);
      e.d    = w[16*b +: 16];
      exp_q.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input bit stall);
    int start = done_cnt[i];
    int n = 0;
    while (done_cnt[i] == start && n < 300) begin
      @(posedge clk);
      #1;
      if (stall) drdy[i] = ~drdy[i];
      n++;
    end
    drdy[i] = 1'b1;
    chk("xfer_done_seen", 64'(n < 300), 64'd1);
  endtask

  task automatic chk_idle_outputs(input string tag, input int i);
    chk({tag, "_re"},    64'(re[i]),     64'd0);
    chk({tag, "_valid"}, 64'(dvalid[i]), 64'd0);
    chk({tag, "_busy"},  64'(busy[i]),   64'd0);
    chk({tag, "_done"},  64'(done[i]),   64'd0);
    chk({tag, "_sop"},   64'(sop[i]),    64'd0);
    chk({tag, "_eop"},   64'(eop[i]),    64'd0);
    chk({tag, "_dout"},  64'(dout[i]),   64'd0);
  endtask

  initial begin
    int r0, d0, b0, v0, s0, e0, n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_ready[i] = 1'b0;
      pckts[i]      = 16'd0;
      drdy[i]       = 1'b1;
    end
    cycles(3);
    chk_idle_outputs("reset0", 0);
    chk_idle_outputs("reset1", 1);
    rst_n = 1'b1;
    cycles(2);

    // single packet, no backpressure
    r0 = re_cnt[0]; d0 = done_cnt[0]; s0 = sop_cnt[0]; e0 = eop_cnt[0];
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    pckts[0] = 16'd1; data_ready[0] = 1'b1;
    wait_done(0, 0);
    cycles(2);
    chk("t1_re_cnt", 64'(re_cnt[0] - r0), 64'd2);
    chk("t1_done_cnt", 64'(done_cnt[0] - d0), 64'd1);
    chk("t1_sop_cnt", 64'(sop_cnt[0] - s0), 64'd1);
    chk("t1_eop_cnt", 64'(eop_cnt[0] - e0), 64'd1);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_busy_after", 64'(busy[0]), 64'd0);
    data_ready[0] = 1'b0;
    cycles(1);

    // alternate-cycle backpressure
    r0 = re_cnt[0];
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    data_ready[0] = 1'b1;
    wait_done(0, 1);
    cycles(2);
    chk("t2_re_cnt", 64'(re_cnt[0] - r0), 64'd2);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    data_ready[0] = 1'b0;
    cycles(1);

    // zero packets must not start anything
    r0 = re_cnt[0]; d0 = done_cnt[0]; b0 = busy_cyc[0]; v0 = valid_cyc[0];
    pckts[0] = 16'd0; data_ready[0] = 1'b1;
    cycles(20);
    chk("t3_re", 64'(re_cnt[0] - r0), 64'd0);
    chk("t3_valid", 64'(valid_cyc[0] - v0), 64'd0);
    chk("t3_busy", 64'(busy_cyc[0] - b0), 64'd0);
    chk("t3_done", 64'(done_cnt[0] - d0), 64'd0);

    // level held high after a transfer must not retrigger
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    pckts[0] = 16'd1;
    wait_done(0, 0);
    r0 = re_cnt[0];
    cycles(50);
    chk("t4_no_retrigger", 64'(re_cnt[0] - r0), 64'd0);
    data_ready[0] = 1'b0;
    cycles(1);
    r0 = re_cnt[0]; s0 = sop_cnt[0]; e0 = eop_cnt[0];
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    push_word(0, W2, 1, 0); push_word(0, W0, 0, 1);
    pckts[0] = 16'd2; data_ready[0] = 1'b1;
    wait_done(0, 0);
    cycles(2);
    chk("t4_re_cnt", 64'(re_cnt[0] - r0), 64'd4);
    chk("t4_sop_cnt", 64'(sop_cnt[0] - s0), 64'd2);
    chk("t4_eop_cnt", 64'(eop_cnt[0] - e0), 64'd2);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
    data_ready[0] = 1'b0;
    cycles(1);

    // reset in the middle of a word
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    pckts[0] = 16'd1; data_ready[0] = 1'b1;
    n = 0;
    while (!(dvalid[0] && dout[0] == 16'h0003) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_beat2", 64'(n < 100), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t5_rst", 0);
    data_ready[0] = 1'b0;
    exp_q.delete();
    fq0.delete();
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    chk("t5_busy_post", 64'(busy[0]), 64'd0);
    r0 = re_cnt[0];
    push_word(0, W0, 1, 0); push_word(0, W1, 0, 1);
    pckts[0] = 16'd1; data_ready[0] = 1'b1;
    wait_done(0, 0);
    cycles(2);
    chk("t5_re_cnt", 64'(re_cnt[0] - r0), 64'd2);
    chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
    data_ready[0] = 1'b0;

    // long read latency, one word per packet
    r0 = re_cnt[1];
    push_word(1, W0, 1, 1); push_word(1, W1, 1, 1); push_word(1, W2, 1, 1);
    pckts[1] = 16'd3; data_ready[1] = 1'b1;
    wait_done(1, 0);
    cycles(2);
    chk("t6_re_cnt", 64'(re_cnt[1] - r0), 64'd3);
    chk("t6_first_latency", 64'(first_val1 - first_re1), 64'd4);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
    data_ready[1] = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
